// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// Pipeline stage register placed at each stage boundary of the core
// (decode/execute/memory/write-back). It moves a control field and a data
// field from one stage to the next with a valid/ready handshake.
//
// Parameters
//   DATA_W  data payload width (operands, PC, destination index)
//   CTRL_W  control payload width; forced to zero in bubbles
//   SKID    1: two-entry skid buffer, in_ready has no path from out_ready
//           0: single entry, in_ready is combinational from out_ready
//   CNT_W   width of the saturating backpressure counter
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (also clears bp_cnt)
//   flush      synchronously discards every held entry and the current input
//   freeze     holds all state; blocks transfers on both sides
//   in_valid   upstream offers an entry
//   in_ready   stage can accept an entry
//   in_ctrl    incoming control payload
//   in_data    incoming data payload
//   out_valid  stage presents an entry
//   out_ready  downstream accepts
//   out_ctrl   outgoing control payload, zero whenever out_valid=0
//   out_data   outgoing data payload, zero whenever the stage is empty
//   count      number of entries held (0..2)
//   bp_cnt     saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 10,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  bp_cnt
);

  // The occupancy state doubles as the entry-valid bits: main is valid in
  // ONE and TWO, skid is valid only in TWO.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic [CNT_W-1:0]    bp_cnt_reg;

  logic                main_valid;
  logic                accept;
  logic                release_out;
  logic                stall;

  assign main_valid = (state_reg != ST_EMPTY);

  // Both handshake terms already include !freeze through in_ready and
  // out_valid, so freeze blocks every transfer without extra gating here.
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Depends only on the state register and freeze, which keeps the
      // upstream ready free of any combinational path from downstream.
      assign in_ready = (state_reg != ST_TWO) & ~freeze;
    end else begin : g_noskid
      // Single entry: a full stage may reload in the cycle it drains.
      assign in_ready = (~main_valid | out_ready) & ~freeze;
    end
  endgenerate

  assign out_valid = main_valid & ~freeze;
  assign out_data  = main_data_reg;
  assign count     = state_reg;
  assign bp_cnt    = bp_cnt_reg;

  // Freeze turns the presented entry into a bubble for the next stage by
  // clearing every control bit.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl[gi] = main_ctrl_reg[gi] & ~freeze;
    end
  endgenerate

  // Next-state and payload movement.
  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;

    if (flush) begin
      // Flush wins over freeze and drops the same-cycle input; a release
      // presented this cycle still completes downstream.
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      main_data_next = '0;
      skid_ctrl_next = '0;
      skid_data_next = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ST_ONE: begin
          if (accept && release_out) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (accept && (SKID != 0)) begin
            // Main is still waiting downstream, so the newer entry parks
            // behind it in the skid slot.
            state_next     = ST_TWO;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end else if (release_out) begin
            state_next     = ST_EMPTY;
            main_ctrl_next = '0;
            main_data_next = '0;
          end
        end
        ST_TWO: begin
          if (release_out) begin
            state_next     = ST_ONE;
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
            skid_ctrl_next = '0;
            skid_data_next = '0;
          end
        end
        default: begin
          state_next     = ST_EMPTY;
          main_ctrl_next = '0;
          main_data_next = '0;
          skid_ctrl_next = '0;
          skid_data_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
    end
  end

  // Backpressure counter: only rst clears it; it sticks at all-ones.
  assign stall = out_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_cnt_reg <= '0;
    end else if (stall && (bp_cnt_reg != {CNT_W{1'b1}})) begin
      bp_cnt_reg <= bp_cnt_reg + CNT_W'(1);
    end
  end

endmodule
